// File: rtl/lif_pkg.sv
// Shared defaults for the leaky integrate-and-fire array and a width-generic saturating add.
package lif_pkg;

  localparam int unsigned LIF_WIDTH        = 8;
  localparam int unsigned LIF_LEAK_SHIFT   = 1;
  localparam int unsigned LIF_REFRAC_STEPS = 2;

  // Unsigned a + b clamped to 2^width-1; supports widths up to 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [63:0] sum;
    logic [63:0] max_val;
    sum     = {32'd0, a} + {32'd0, b};
    max_val = (64'd1 << width) - 64'd1;
    if (sum > max_val) begin
      sat_add = max_val[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane register, refractory counter, registered spike.
module lif_cell
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH        = LIF_WIDTH,
  parameter int unsigned LEAK_SHIFT   = LIF_LEAK_SHIFT,
  parameter int unsigned REFRAC_STEPS = LIF_REFRAC_STEPS
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] current_i,
  input  logic [WIDTH-1:0] threshold_i,
  output logic [WIDTH-1:0] state_o,
  output logic             spike_o,
  output logic             refractory_o,
  output logic             spike_next_o
);

  localparam int unsigned RefW = (REFRAC_STEPS == 0) ? 1 : $clog2(REFRAC_STEPS + 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [RefW-1:0]  refrac_q, refrac_d;
  logic             spike_q, spike_d;
  logic [WIDTH-1:0] integ;

  // Leaked state plus input current, clamped at full scale.
  assign integ = WIDTH'(sat_add(32'(current_i), 32'(state_q >> LEAK_SHIFT), WIDTH));

  always_comb begin
    state_d  = state_q;
    refrac_d = refrac_q;
    spike_d  = 1'b0;
    if (step_i) begin
      if (refrac_q != '0) begin
        state_d  = '0;
        refrac_d = refrac_q - RefW'(1);
      end else if ((threshold_i != '0) && (integ >= threshold_i)) begin
        spike_d  = 1'b1;
        state_d  = '0;
        refrac_d = RefW'(REFRAC_STEPS);
      end else begin
        state_d = integ;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= '0;
      refrac_q <= '0;
      spike_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      refrac_q <= refrac_d;
      spike_q  <= spike_d;
    end
  end

  assign state_o      = state_q;
  assign spike_o      = spike_q;
  assign refractory_o = (refrac_q != '0);
  assign spike_next_o = spike_d;

endmodule

// File: rtl/lif_array.sv
// Array of LIF neurons stepped by in_valid beats, with out_valid and a saturating spike total.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS    = 4,
  parameter int unsigned WIDTH        = LIF_WIDTH,
  parameter int unsigned LEAK_SHIFT   = LIF_LEAK_SHIFT,
  parameter int unsigned REFRAC_STEPS = LIF_REFRAC_STEPS,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_valid_i,
  input  logic [N_NEURONS*WIDTH-1:0] current_i,
  input  logic [WIDTH-1:0]           threshold_i,
  output logic                       out_valid_o,
  output logic [N_NEURONS-1:0]       spike_o,
  output logic [N_NEURONS*WIDTH-1:0] state_o,
  output logic [N_NEURONS-1:0]       refractory_o,
  output logic [CNT_W-1:0]           spike_cnt_o
);

  logic [N_NEURONS-1:0] spike_next;
  logic                 out_valid_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          pop;

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_cell
    lif_cell #(
      .WIDTH       (WIDTH),
      .LEAK_SHIFT  (LEAK_SHIFT),
      .REFRAC_STEPS(REFRAC_STEPS)
    ) u_cell (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .step_i      (in_valid_i),
      .current_i   (current_i[i*WIDTH +: WIDTH]),
      .threshold_i (threshold_i),
      .state_o     (state_o[i*WIDTH +: WIDTH]),
      .spike_o     (spike_o[i]),
      .refractory_o(refractory_o[i]),
      .spike_next_o(spike_next[i])
    );
  end

  // Count the spikes that land on this edge so spike_cnt tracks spike exactly.
  always_comb begin
    pop = 32'd0;
    for (int i = 0; i < N_NEURONS; i++) begin
      pop = pop + 32'(spike_next[i]);
    end
    cnt_d = CNT_W'(sat_add(32'(cnt_q), pop, CNT_W));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= in_valid_i;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign spike_cnt_o = cnt_q;

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: directed table, corner sequences and random beats vs a model.
module tb_lif_array;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] current = '0;
  logic [7:0]  threshold = '0;

  logic        out_valid, out_valid3;
  logic [3:0]  spike, spike3, refr, refr3;
  logic [31:0] state, state3;
  logic [15:0] spike_cnt;
  logic [2:0]  spike_cnt3;

  always #5 clk = ~clk;

  lif_array #(.N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC_STEPS(2), .CNT_W(16)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .current_i   (current),
    .threshold_i (threshold),
    .out_valid_o (out_valid),
    .spike_o     (spike),
    .state_o     (state),
    .refractory_o(refr),
    .spike_cnt_o (spike_cnt)
  );

  lif_array #(.N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC_STEPS(2), .CNT_W(3)) dut3 (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .current_i   (current),
    .threshold_i (threshold),
    .out_valid_o (out_valid3),
    .spike_o     (spike3),
    .state_o     (state3),
    .refractory_o(refr3),
    .spike_cnt_o (spike_cnt3)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model kept as plain integers.
  int m_st[4];
  int m_rc[4];
  int m_cnt, m_cnt3;
  bit m_ov;
  bit [3:0] m_sp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [31:0] cur,
                            input logic [7:0] thr);
    int pop;
    int ns;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_st[i] = 0;
        m_rc[i] = 0;
      end
      m_cnt = 0; m_cnt3 = 0; m_ov = 0; m_sp = '0;
    end else if (!v) begin
      m_ov = 0;
      m_sp = '0;
    end else begin
      m_ov = 1;
      pop  = 0;
      for (int i = 0; i < 4; i++) begin
        m_sp[i] = 1'b0;
        if (m_rc[i] > 0) begin
          m_st[i] = 0;
          m_rc[i] = m_rc[i] - 1;
        end else begin
          ns = int'(cur[i*8 +: 8]) + m_st[i] / 2;
          if (ns > 255) ns = 255;
          if (thr != 0 && ns >= int'(thr)) begin
            m_sp[i] = 1'b1;
            m_st[i] = 0;
            m_rc[i] = 2;
            pop++;
          end else begin
            m_st[i] = ns;
          end
        end
      end
      m_cnt  = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
      m_cnt3 = (m_cnt3 + pop > 7) ? 7 : m_cnt3 + pop;
    end
  endtask

  function automatic logic [31:0] model_state();
    logic [31:0] s;
    for (int i = 0; i < 4; i++) s[i*8 +: 8] = 8'(m_st[i]);
    return s;
  endfunction

  function automatic logic [3:0] model_refr();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_rc[i] != 0);
    return r;
  endfunction

  // Drives one cycle (called at a negedge) and compares both DUTs to the model afterwards.
  task automatic beat(input bit r, input bit v, input logic [31:0] cur, input logic [7:0] thr);
    reset = r; in_valid = v; current = cur; threshold = thr;
    model_step(r, v, cur, thr);
    @(negedge clk);
    check("model_out_valid", 64'(out_valid), 64'(m_ov));
    check("model_spike", 64'(spike), 64'(m_sp));
    check("model_state", 64'(state), 64'(model_state()));
    check("model_refractory", 64'(refr), 64'(model_refr()));
    check("model_spike_cnt", 64'(spike_cnt), 64'(m_cnt));
    check("model_spike_cnt3", 64'(spike_cnt3), 64'(m_cnt3));
    if (!out_valid) check("spike_idle_zero", 64'(spike), 64'd0);
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] cur;
    logic [7:0]  thr;
    logic [3:0]  e_sp;
    logic [31:0] e_st;
    logic [3:0]  e_rf;
    bit          e_ov;
    int          e_cnt;
    int          e_cnt3;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit v, logic [31:0] c, logic [7:0] t, logic [3:0] sp,
                              logic [31:0] st, logic [3:0] rf, bit ov, int cn, int cn3);
    vec_t x;
    x.rst = r; x.v = v; x.cur = c; x.thr = t; x.e_sp = sp; x.e_st = st;
    x.e_rf = rf; x.e_ov = ov; x.e_cnt = cn; x.e_cnt3 = cn3;
    return x;
  endfunction

  initial begin
    logic [31:0] rc;
    logic [7:0]  rt;
    // Sub-threshold integration with a gap
    vecs.push_back(mk(1, 0, 32'h0, 8'd10, 4'h0, 32'h00, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h4, 8'd10, 4'h0, 32'h04, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h4, 8'd10, 4'h0, 32'h06, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h4, 8'd10, 4'h0, 32'h06, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h4, 8'd10, 4'h0, 32'h07, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h4, 8'd10, 4'h0, 32'h07, 4'h0, 1, 0, 0));
    // Fire then refractory, with a gap inside the refractory window
    vecs.push_back(mk(1, 0, 32'h0, 8'd10, 4'h0, 32'h00, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h6, 8'd10, 4'h0, 32'h06, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h6, 8'd10, 4'h0, 32'h09, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h6, 8'd10, 4'h1, 32'h00, 4'h1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 32'h6, 8'd10, 4'h0, 32'h00, 4'h1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h6, 8'd10, 4'h0, 32'h00, 4'h1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 32'h6, 8'd10, 4'h0, 32'h00, 4'h0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 32'h6, 8'd10, 4'h0, 32'h06, 4'h0, 1, 1, 1));
    // Simultaneous firing and small-counter saturation
    vecs.push_back(mk(0, 1, 32'h0c0c0c0c, 8'd10, 4'hf, 32'h0, 4'hf, 1, 5, 5));
    vecs.push_back(mk(0, 1, 32'h0c0c0c0c, 8'd10, 4'h0, 32'h0, 4'hf, 1, 5, 5));
    vecs.push_back(mk(0, 1, 32'h0c0c0c0c, 8'd10, 4'h0, 32'h0, 4'h0, 1, 5, 5));
    vecs.push_back(mk(0, 1, 32'h0c0c0c0c, 8'd10, 4'hf, 32'h0, 4'hf, 1, 9, 7));
    // Reset beats a concurrent valid while refractory
    vecs.push_back(mk(1, 1, 32'h6, 8'd10, 4'h0, 32'h00, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h6, 8'd10, 4'h0, 32'h06, 4'h0, 1, 0, 0));
    // Threshold zero: saturate, never fire
    vecs.push_back(mk(1, 0, 32'h0, 8'd0, 4'h0, 32'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000ff00, 8'd0, 4'h0, 32'h0000ff00, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000ff00, 8'd0, 4'h0, 32'h0000ff00, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000ff00, 8'd0, 4'h0, 32'h0000ff00, 4'h0, 1, 0, 0));

    @(negedge clk);
    foreach (vecs[k]) begin
      beat(vecs[k].rst, vecs[k].v, vecs[k].cur, vecs[k].thr);
      check($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].e_ov));
      check($sformatf("vec%0d_spike", k), 64'(spike), 64'(vecs[k].e_sp));
      check($sformatf("vec%0d_state", k), 64'(state), 64'(vecs[k].e_st));
      check($sformatf("vec%0d_refractory", k), 64'(refr), 64'(vecs[k].e_rf));
      check($sformatf("vec%0d_spike_cnt", k), 64'(spike_cnt), 64'(vecs[k].e_cnt));
      check($sformatf("vec%0d_spike_cnt3", k), 64'(spike_cnt3), 64'(vecs[k].e_cnt3));
    end

    // Held registers across a run of idle cycles after a firing beat
    beat(1'b1, 1'b0, 32'h0, 8'd10);
    beat(1'b0, 1'b1, 32'h0b000000, 8'd10);
    check("seq_fire_n3", 64'(spike), 64'h8);
    for (int k = 0; k < 3; k++) beat(1'b0, 1'b0, 32'hffffffff, 8'd10);
    check("seq_hold_refr", 64'(refr), 64'h8);
    check("seq_hold_cnt", 64'(spike_cnt), 64'd1);

    // Random beats
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        rc[i*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255))
                                                      : 8'($urandom_range(0, 20));
      end
      case ($urandom_range(0, 4))
        0:       rt = 8'd0;
        1:       rt = 8'd255;
        2:       rt = 8'($urandom);
        default: rt = 8'($urandom_range(5, 30));
      endcase
      beat($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rc, rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
